// File: rtl/proc_feeder.sv
// Instruction sourcing unit: prefetches ROM words into a small FIFO and drives DIN in the processor's slot/imm cycles.
// Optional issued-instruction counter enabled by defining PROC_FEEDER_STATS_EN.
module proc_feeder #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  input  logic              Done,
  output logic [8:0]        DIN,
  output logic              Run,
  output logic              BadOp,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemRd,
  input  logic [8:0]        MemData,
  output logic [15:0]       InstrCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [2:0] OP_MVI = 3'b001;

  logic              first_q;
  logic              done_q;
  logic              imm_q;
  logic              inflight_q;
  logic [ADDR_W-1:0] pc_q;
  logic [8:0]        fifo_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  occupancy;
  logic              slot;
  logic              push;
  logic              pop;
  logic              imm_next;
  logic              fetch;
  logic [8:0]        head;
  logic [2:0]        head_op;

  assign slot      = first_q | done_q;
  assign head      = fifo_q[rd_ptr_q];
  assign head_op   = head[8:6];
  assign push      = inflight_q;
  // Reads still in flight are counted so the FIFO can never overflow.
  assign occupancy = count_q + CNT_W'(inflight_q);
  assign fetch     = Resetn & Go & (occupancy < CNT_W'(DEPTH));
  assign MemRd     = fetch;
  assign MemAddr   = pc_q;

  always_comb begin
    DIN      = '0;
    Run      = 1'b0;
    BadOp    = 1'b0;
    pop      = 1'b0;
    imm_next = 1'b0;
    if (imm_q) begin
      DIN = head;
      pop = 1'b1;
    end else if (slot && (count_q != '0)) begin
      if (head_op[2]) begin
        BadOp = 1'b1;
        pop   = 1'b1;
      end else if (Go && (head_op != OP_MVI)) begin
        DIN = head;
        Run = 1'b1;
        pop = 1'b1;
      end else if (Go && (count_q >= CNT_W'(2))) begin
        // mvi only leaves with its immediate already buffered behind it.
        DIN      = head;
        Run      = 1'b1;
        pop      = 1'b1;
        imm_next = 1'b1;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      first_q    <= 1'b1;
      done_q     <= 1'b0;
      imm_q      <= 1'b0;
      inflight_q <= 1'b0;
      pc_q       <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      first_q    <= 1'b0;
      done_q     <= Done;
      imm_q      <= imm_next;
      inflight_q <= fetch;
      if (fetch) pc_q <= pc_q + ADDR_W'(1);
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (push) fifo_q[wr_ptr_q] <= MemData;
  end

`ifdef PROC_FEEDER_STATS_EN
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      InstrCount <= '0;
    end else if (Run && (InstrCount != 16'hFFFF)) begin
      InstrCount <= InstrCount + 16'd1;
    end
  end
`else
  assign InstrCount = '0;
`endif

endmodule

// File: tb/tb_proc_feeder.sv
// Bench for proc_feeder: ROM and processor models, directed program table, randomized run against a queue model.
module tb_proc_feeder;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;
  localparam int ROM_N  = 1 << ADDR_W;

  logic              Clock = 1'b0;
  logic              Resetn;
  logic              Go;
  logic              Done;
  logic [8:0]        DIN;
  logic              Run;
  logic              BadOp;
  logic [ADDR_W-1:0] MemAddr;
  logic              MemRd;
  logic [8:0]        MemData;
  logic [15:0]       InstrCount;

  logic [8:0] rom [ROM_N];
  logic [8:0] preg [8];
  logic [8:0] pir;
  int         pstep;
  int         plen;

  int total = 0;
  int bad   = 0;

  logic [8:0] mq_data [$];
  int         mq_ready [$];
  int         maddr, mcyc, mcount, nbad;
  bit         mfirst, mprev_done, mimm;

  typedef struct {
    logic [7:0][8:0] prog;
    int              len;
    bit              go;
    int              cycles;
    int              reg_idx;
    int              reg_val;
    int              badops;
  } vec_t;

  vec_t vecs [4];

  proc_feeder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .Clock(Clock), .Resetn(Resetn), .Go(Go), .Done(Done),
    .DIN(DIN), .Run(Run), .BadOp(BadOp),
    .MemAddr(MemAddr), .MemRd(MemRd), .MemData(MemData),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    if (MemRd) MemData <= rom[MemAddr];
  end

  // Processor: mv/mvi take 2 steps, add/sub take 4; Done is raised in the last step.
  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pstep = 0;
      plen  = 2;
      pir   = '0;
      Done <= 1'b0;
      for (int i = 0; i < 8; i++) preg[i] = '0;
    end else if (pstep == 0) begin
      pir   = DIN;
      plen  = (pir[8:6] == 3'd2 || pir[8:6] == 3'd3) ? 4 : 2;
      pstep = 1;
      Done <= (plen == 2);
    end else begin
      if (pstep == 1 && pir[8:6] == 3'd1) preg[pir[5:3]] = DIN;
      if (pstep == plen - 1) begin
        case (pir[8:6])
          3'd0: preg[pir[5:3]] = preg[pir[2:0]];
          3'd2: preg[pir[5:3]] = preg[pir[5:3]] + preg[pir[2:0]];
          3'd3: preg[pir[5:3]] = preg[pir[5:3]] - preg[pir[2:0]];
          default: ;
        endcase
        pstep = 0;
        Done <= 1'b0;
      end else begin
        pstep = pstep + 1;
        Done <= (pstep == plen - 1);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, mcyc);
    end
  endtask

  task automatic model_reset();
    mq_data.delete();
    mq_ready.delete();
    maddr      = 0;
    mcyc       = 0;
    mcount     = 0;
    mfirst     = 1'b1;
    mprev_done = 1'b0;
    mimm       = 1'b0;
    nbad       = 0;
  endtask

  // Ends at posedge+1 with reset released; that cycle is the first slot.
  task automatic do_reset();
    Resetn = 1'b0;
    @(posedge Clock);
    @(posedge Clock);
    #1;
    model_reset();
    Resetn = 1'b1;
  endtask

  // One cycle: drive Go at posedge+1, compare at the falling edge, advance the model.
  task automatic step(input bit go_v);
    bit         slot, pop, imm_n, exp_rd, exp_run, exp_bad;
    int         avail;
    logic [8:0] head, exp_din;
    Go = go_v;
    @(negedge Clock);
    slot    = mfirst | mprev_done;
    avail   = 0;
    foreach (mq_ready[i]) if (mq_ready[i] <= mcyc) avail++;
    head    = (mq_data.size() > 0) ? mq_data[0] : 9'd0;
    exp_din = '0;
    exp_run = 1'b0;
    exp_bad = 1'b0;
    pop     = 1'b0;
    imm_n   = 1'b0;
    exp_rd  = go_v && (mq_data.size() < DEPTH);
    chk("MemRd", int'(MemRd), int'(exp_rd));
    chk("MemAddr", int'(MemAddr), maddr);
    if (mimm) begin
      exp_din = head;
      pop     = 1'b1;
    end else if (slot && avail >= 1) begin
      if (head[8]) begin
        exp_bad = 1'b1;
        pop     = 1'b1;
      end else if (go_v && head[8:6] != 3'd1) begin
        exp_din = head;
        exp_run = 1'b1;
        pop     = 1'b1;
      end else if (go_v && avail >= 2) begin
        exp_din = head;
        exp_run = 1'b1;
        pop     = 1'b1;
        imm_n   = 1'b1;
      end
    end
    chk("DIN", int'(DIN), int'(exp_din));
    chk("Run", int'(Run), int'(exp_run));
    chk("BadOp", int'(BadOp), int'(exp_bad));
    chk("InstrCount", int'(InstrCount), mcount);
`ifdef PROC_FEEDER_STATS_EN
    if (exp_run && mcount < 65535) mcount++;
`endif
    if (BadOp) nbad++;
    if (pop) begin
      void'(mq_data.pop_front());
      void'(mq_ready.pop_front());
    end
    if (exp_rd) begin
      mq_data.push_back(rom[maddr]);
      mq_ready.push_back(mcyc + 2);
      maddr = (maddr + 1) % ROM_N;
    end
    mprev_done = Done;
    mfirst     = 1'b0;
    mimm       = imm_n;
    mcyc++;
    @(posedge Clock);
    #1;
  endtask

  task automatic load_prog(input vec_t v);
    for (int i = 0; i < ROM_N; i++) rom[i] = (i < v.len) ? v.prog[i] : 9'd0;
  endtask

  initial begin
    Resetn = 1'b1;
    Go     = 1'b0;
    for (int i = 0; i < ROM_N; i++) rom[i] = '0;
    #2 Resetn = 1'b0;

    vecs[0].prog = '0; vecs[0].prog[0] = 9'o100; vecs[0].prog[1] = 9'o005; vecs[0].prog[2] = 9'o010;
    vecs[0].len = 3; vecs[0].go = 1'b1; vecs[0].cycles = 30; vecs[0].reg_idx = 1; vecs[0].reg_val = 5; vecs[0].badops = 0;

    vecs[1].prog = '0; vecs[1].prog[0] = 9'o100; vecs[1].prog[1] = 9'd3; vecs[1].prog[2] = 9'o110;
    vecs[1].prog[3] = 9'd4; vecs[1].prog[4] = 9'o201;
    vecs[1].len = 5; vecs[1].go = 1'b1; vecs[1].cycles = 30; vecs[1].reg_idx = 0; vecs[1].reg_val = 7; vecs[1].badops = 0;

    vecs[2].prog = vecs[1].prog;
    vecs[2].len = 5; vecs[2].go = 1'b0; vecs[2].cycles = 20; vecs[2].reg_idx = 0; vecs[2].reg_val = 0; vecs[2].badops = 0;

    vecs[3].prog = '0; vecs[3].prog[0] = 9'o100; vecs[3].prog[1] = 9'd6; vecs[3].prog[2] = 9'o010;
    vecs[3].prog[3] = 9'o400; vecs[3].prog[4] = 9'o020;
    vecs[3].len = 5; vecs[3].go = 1'b1; vecs[3].cycles = 40; vecs[3].reg_idx = 2; vecs[3].reg_val = 6; vecs[3].badops = 1;

    for (int t = 0; t < 4; t++) begin
      Resetn = 1'b0;
      load_prog(vecs[t]);
      do_reset();
      repeat (vecs[t].cycles) step(vecs[t].go);
      chk($sformatf("vec%0d_reg", t), int'(preg[vecs[t].reg_idx]), vecs[t].reg_val);
      chk($sformatf("vec%0d_badops", t), nbad, vecs[t].badops);
    end

    // Asynchronous reset during step 2 of the add (slot at cycle 8).
    Resetn = 1'b0;
    load_prog(vecs[1]);
    do_reset();
    repeat (10) step(1'b1);
    chk("pre_reset_step", pstep, 2);
    #1 Resetn = 1'b0;
    #1;
    chk("async_DIN", int'(DIN), 0);
    chk("async_Run", int'(Run), 0);
    chk("async_BadOp", int'(BadOp), 0);
    chk("async_MemRd", int'(MemRd), 0);
    chk("async_MemAddr", int'(MemAddr), 0);
    chk("async_InstrCount", int'(InstrCount), 0);
    do_reset();
    repeat (30) step(1'b1);
    chk("after_reset_reg", int'(preg[0]), 7);

    // Randomized program and Go pattern with occasional resets.
    Resetn = 1'b0;
    for (int i = 0; i < ROM_N; i++) rom[i] = 9'($urandom_range(0, 511));
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if (k % 300 == 299) begin
        #1 Resetn = 1'b0;
        do_reset();
      end
      step($urandom_range(0, 9) < 7);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
